// File: rtl/ps2_rx_fifo_pkg.sv
// ps2_pkg: shared types and constants for the PS/2 receiver slice.
//   state_t    - receiver FSM states
//   PS2_BREAK  - break (key release) prefix byte
//   PS2_EXT    - extended-key prefix byte
//   ps2_code_t - decoded entry as stored in the FIFO: {ext, brk, code}
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    CHECK
  } state_t;

  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_code_t;

  // PS/2 uses odd parity: data bits plus parity bit must XOR to 1.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_rx_fifo_if.sv
// ps2_rx_fifo_if: valid/ready stream carrying decoded PS/2 entries.
//   m_valid - producer has an entry at the head
//   m_ready - consumer accepts the head entry this cycle
//   m_data  - {ext, brk, code[7:0]}
interface ps2_rx_fifo_if;
  logic       m_valid;
  logic       m_ready;
  logic [9:0] m_data;

  modport master (output m_valid, output m_data, input m_ready);
  modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/ps2_rx_fifo_sync_fifo.sv
// ps2_sync_fifo: single-clock show-ahead FIFO.
//   clk, rst   - clock, asynchronous active-low reset
//   push       - write request (accepted when not full, or full with a pop)
//   push_data  - write data
//   pop        - read request (ignored when empty)
//   rd_data    - head entry, valid whenever empty=0; reads 0 when empty
//   empty/full - occupancy flags
//   level      - current occupancy
module ps2_sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop_ok  = pop & ~empty;
  // When full, a simultaneous pop frees the slot being written.
  assign push_ok = push & (~full | pop_ok);
  assign level   = LW'(wr_ptr_reg - rd_ptr_reg);
  assign rd_data = empty ? '0 : mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with show-ahead output FIFO,
// frame watchdog, per-cause error pulses and optional F0/E0 prefix folding.
//   clk, rst            - clock, asynchronous active-low reset
//   ps2_clk, ps2_data   - raw PS/2 pins
//   m (master)          - valid/ready stream of {ext, brk, code}
//   level               - FIFO occupancy
//   parity_err          - pulse: frame dropped, bad parity
//   frame_err           - pulse: frame dropped, stop bit 0
//   timeout_err         - pulse: watchdog expired mid-frame
//   overflow            - pulse: good byte dropped, FIFO full
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FIFO_DEPTH     = 16,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DECODE         = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ps2_clk,
  input  logic                              ps2_data,
  ps2_rx_fifo_if.master                     m,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              parity_err,
  output logic                              frame_err,
  output logic                              timeout_err,
  output logic                              overflow
);

  localparam int               WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  // Synchronisers reset to 1 (PS/2 idle) so reset never fakes a falling edge.
  logic [SYNC_STAGES-1:0] clk_sync_reg;
  logic [SYNC_STAGES-1:0] data_sync_reg;
  logic                   clk_prev_reg;
  logic                   fall;
  logic                   bit_in;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_reg  <= '1;
      data_sync_reg <= '1;
      clk_prev_reg  <= 1'b1;
    end else begin
      clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
      data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
      clk_prev_reg  <= clk_sync_reg[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev_reg & ~clk_sync_reg[SYNC_STAGES-1];
  assign bit_in = data_sync_reg[SYNC_STAGES-1];

  state_t          state_reg;
  logic [2:0]      bit_cnt_reg;
  logic [7:0]      shift_reg;
  logic            par_bit_reg;
  logic            stop_bit_reg;
  logic [WD_W-1:0] wd_cnt_reg;
  logic            ext_reg;
  logic            brk_reg;

  logic            parity_ok;
  logic            frame_good;
  logic            is_prefix;
  logic            push_req;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  ps2_code_t       push_data;

  assign parity_ok  = odd_parity_ok(shift_reg, par_bit_reg);
  assign frame_good = (state_reg == CHECK) && parity_ok && stop_bit_reg;
  assign is_prefix  = (DECODE != 0) &&
                      ((shift_reg == PS2_BREAK) || (shift_reg == PS2_EXT));
  // The FIFO write lands on the edge that leaves CHECK.
  assign push_req   = frame_good & ~is_prefix;
  assign push_data  = '{ext: ext_reg, brk: brk_reg, code: shift_reg};
  assign pop        = m.m_valid & m.m_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      bit_cnt_reg  <= '0;
      shift_reg    <= '0;
      par_bit_reg  <= 1'b0;
      stop_bit_reg <= 1'b0;
      wd_cnt_reg   <= '0;
      ext_reg      <= 1'b0;
      brk_reg      <= 1'b0;
      parity_err   <= 1'b0;
      frame_err    <= 1'b0;
      timeout_err  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      timeout_err <= 1'b0;
      overflow    <= push_req & fifo_full & ~pop;

      case (state_reg)
        IDLE: begin
          wd_cnt_reg <= '0;
          // A falling edge with data high is a false start and is ignored.
          if (fall && !bit_in) begin
            state_reg   <= DATA;
            bit_cnt_reg <= '0;
          end
        end

        DATA, PARITY, STOP: begin
          if (fall) begin
            wd_cnt_reg <= '0;
            case (state_reg)
              DATA: begin
                shift_reg   <= {bit_in, shift_reg[7:1]};
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                if (bit_cnt_reg == 3'd7) state_reg <= PARITY;
              end
              PARITY: begin
                par_bit_reg <= bit_in;
                state_reg   <= STOP;
              end
              default: begin
                stop_bit_reg <= bit_in;
                state_reg    <= CHECK;
              end
            endcase
          end else if (wd_cnt_reg == WD_LAST) begin
            // Stalled frame: drop it and forget any pending prefix.
            timeout_err <= 1'b1;
            state_reg   <= IDLE;
            wd_cnt_reg  <= '0;
            ext_reg     <= 1'b0;
            brk_reg     <= 1'b0;
          end else begin
            wd_cnt_reg <= wd_cnt_reg + 1'b1;
          end
        end

        CHECK: begin
          state_reg <= IDLE;
          if (!parity_ok) begin
            parity_err <= 1'b1;
          end else if (!stop_bit_reg) begin
            frame_err <= 1'b1;
          end else if (DECODE != 0) begin
            if (shift_reg == PS2_BREAK) begin
              brk_reg <= 1'b1;
            end else if (shift_reg == PS2_EXT) begin
              ext_reg <= 1'b1;
            end else begin
              ext_reg <= 1'b0;
              brk_reg <= 1'b0;
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  logic [9:0] head_data;

  ps2_sync_fifo #(
    .WIDTH (10),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_data),
    .pop       (pop),
    .rd_data   (head_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (level)
  );

  assign m.m_valid = ~fifo_empty;
  assign m.m_data  = head_data;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
module tb_ps2_rx_fifo;

  localparam int TIMEOUT = 200;
  localparam int HALF    = 10;
  localparam int GAP     = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [4:0] level;
  logic       parity_err, frame_err, timeout_err, overflow;

  ps2_rx_fifo_if bus ();

  ps2_rx_fifo #(
    .SYNC_STAGES    (2),
    .FIFO_DEPTH     (16),
    .TIMEOUT_CYCLES (TIMEOUT),
    .DECODE         (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .m           (bus),
    .level       (level),
    .parity_err  (parity_err),
    .frame_err   (frame_err),
    .timeout_err (timeout_err),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_par = 0, n_frm = 0, n_to = 0, n_ovf = 0;
  int valid_cycles = 0;
  logic [9:0] exp_q[$];

  // Monitor: pops the scoreboard on every accepted entry and counts pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (bus.m_valid) valid_cycles++;
      if (parity_err)  n_par++;
      if (frame_err)   n_frm++;
      if (timeout_err) n_to++;
      if (overflow)    n_ovf++;
      if (bus.m_valid && bus.m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected got=%h required=none", bus.m_data);
        end else begin
          logic [9:0] e;
          e = exp_q.pop_front();
          if (bus.m_data !== e) begin
            failures++;
            $display("FAIL pop_data got=%h required=%h", bus.m_data, e);
          end else begin
            $display("pop m_data=%h ok", bus.m_data);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  // Full 11-bit frame. ready_pulse raises m_ready for exactly the cycle
  // ending in the FIFO write edge (stop fall + 3 sync/detect edges + 1).
  task automatic send_frame(input logic [7:0] b, input bit flip_par,
                            input bit stop_v, input bit ready_pulse);
    logic [10:0] bits;
    bits = {stop_v, (~^b) ^ flip_par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      repeat (HALF) tick();
      ps2_clk = 1'b0;
      if (i == 10 && ready_pulse) begin
        repeat (3) tick();
        bus.m_ready = 1'b1;
        tick();
        bus.m_ready = 1'b0;
        repeat (HALF - 4) tick();
      end else begin
        repeat (HALF) tick();
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (GAP) tick();
    $display("frame %h sent flip_par=%0d stop=%0d", b, flip_par, stop_v);
  endtask

  // Start bit plus n data bits (all ones), then the clock stays high.
  task automatic partial(input int n);
    for (int i = 0; i <= n; i++) begin
      ps2_data = (i == 0) ? 1'b0 : 1'b1;
      repeat (HALF) tick();
      ps2_clk = 1'b0;
      repeat (HALF) tick();
      ps2_clk = 1'b1;
    end
  endtask

  initial begin
    int v0;
    bus.m_ready = 1'b0;
    repeat (5) tick();
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_level", level, 0);
    rst = 1'b1;
    repeat (5) tick();
    check("post_rst_m_data", bus.m_data, 0);
    check("post_rst_pulses", {parity_err, frame_err, timeout_err, overflow}, 0);

    // Single frame with consumer ready.
    bus.m_ready = 1'b1;
    v0 = valid_cycles;
    exp_q.push_back(10'h01C);
    send_frame(8'h1C, 0, 1, 0);
    check("t1_valid_cycles", valid_cycles - v0, 1);
    check("t1_level", level, 0);

    // Prefix folding.
    exp_q.push_back(10'h375);
    exp_q.push_back(10'h01C);
    send_frame(8'hE0, 0, 1, 0);
    send_frame(8'hF0, 0, 1, 0);
    send_frame(8'h75, 0, 1, 0);
    send_frame(8'h1C, 0, 1, 0);
    check("t2_sb_empty", exp_q.size(), 0);

    // Parity and framing errors.
    send_frame(8'h1C, 1, 1, 0);
    check("parity_err_count", n_par, 1);
    check("parity_no_frame_err", n_frm, 0);
    send_frame(8'h1C, 0, 0, 0);
    check("frame_err_count", n_frm, 1);
    check("frame_no_parity_err", n_par, 1);

    // Watchdog: pending E0 must be discarded with the stalled frame.
    send_frame(8'hE0, 0, 1, 0);
    partial(4);
    repeat (150) tick();
    check("timeout_not_early", n_to, 0);
    repeat (150) tick();
    check("timeout_count", n_to, 1);
    exp_q.push_back(10'h029);
    send_frame(8'h29, 0, 1, 0);
    check("t4_sb_empty", exp_q.size(), 0);

    // Overflow, then push+pop while full.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i < 16) exp_q.push_back(10'(8'h10 + i));
      send_frame(8'(8'h10 + i), 0, 1, 0);
    end
    check("full_level", level, 16);
    check("overflow_count", n_ovf, 1);
    exp_q.push_back(10'h055);
    send_frame(8'h55, 0, 1, 1);
    check("full_pushpop_level", level, 16);
    check("full_pushpop_no_ovf", n_ovf, 1);
    bus.m_ready = 1'b1;
    repeat (40) tick();
    check("drain_level", level, 0);
    check("drain_sb_empty", exp_q.size(), 0);

    // Reset mid-frame with a stored entry and a pending break prefix.
    bus.m_ready = 1'b0;
    send_frame(8'h33, 0, 1, 0);
    check("pre_rst_level", level, 1);
    send_frame(8'hF0, 0, 1, 0);
    partial(5);
    rst = 1'b0;
    #1;
    check("mid_rst_m_valid", bus.m_valid, 0);
    check("mid_rst_m_data", bus.m_data, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_pulses", {parity_err, frame_err, timeout_err, overflow}, 0);
    ps2_data = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    repeat (3) tick();
    bus.m_ready = 1'b1;
    exp_q.push_back(10'h05A);
    send_frame(8'h5A, 0, 1, 0);
    check("final_sb_empty", exp_q.size(), 0);
    check("final_parity_err", n_par, 1);
    check("final_frame_err", n_frm, 1);
    check("final_timeout_err", n_to, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

Parametrised PS/2 device-to-host receiver with a built-in show-ahead FIFO, a frame watchdog, per-cause error reporting and optional scan-code prefix decoding. It sits between the board PS/2 pins and any consumer (seven-segment display path, CPU MMIO keyboard register). The consumer drains it over a valid/ready interface. It is the next generation of the team's single-depth, free-running PS/2 receiver.

## Interface
- `SYNC_STAGES`, 2: synchroniser flops on `ps2_clk` and `ps2_data`; must be ≥2.
- `FIFO_DEPTH`, 16: number of entries; must be a power of two and ≥2.
- `TIMEOUT_CYCLES`, 50000: `clk` cycles allowed between PS/2 falling edges inside a frame.
- `DECODE`, 1: when 1, fold `F0`/`E0` prefixes into flag bits; when 0, pass every byte through raw.
- Timing: one clock; reset is asynchronous and active-low.
- `clk`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-low reset.
- `ps2_clk`, in, 1: raw PS/2 clock pin.
- `ps2_data`, in, 1: raw PS/2 data pin.
- `m_valid`, out, 1: FIFO not empty.
- `m_ready`, in, 1: consumer accepts the head entry.
- `m_data`, out, 10: {ext, brk, code[7:0]}; bits 9:8 are always 0 when `DECODE`=0.
- `level`, out, $clog2(FIFO_DEPTH+1): current FIFO occupancy.
- `parity_err`, out, 1: one-cycle pulse when a frame is dropped for bad parity.
- `frame_err`, out, 1: one-cycle pulse when a frame is dropped because its stop bit was 0.
- `timeout_err`, out, 1: one-cycle pulse when the frame watchdog expires.
- `overflow`, out, 1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- Both pins pass through `SYNC_STAGES` flops. A falling edge is detected when the previous synchronised clock was 1 and the current one is 0. All bit sampling uses synchronised data on a detected falling edge.
- FSM states and transitions:
  - IDLE: on a falling edge with data=0, go to DATA with bit count 0. On a falling edge with data=1 (false start), stay in IDLE; no error is raised.
  - DATA: shift bits in LSB first. After the 8th bit, go to PARITY.
  - PARITY: store the parity bit, then go to STOP.
  - STOP: store the stop bit, then go to CHECK.
  - CHECK: lasts exactly one cycle, then returns to IDLE.
- Evaluation in CHECK:
  - Parity is good when the XOR of the 8 data bits and the parity bit is 1 (odd parity).
  - If parity is bad, pulse `parity_err`. Otherwise, if the stop bit is 0, pulse `frame_err`. Only one error pulse is raised per frame; parity takes priority.
  - If the frame is good, it produces a byte.
- Watchdog:
  - The counter clears in IDLE and on every falling edge.
  - It increments in DATA, PARITY and STOP.
  - When it reaches `TIMEOUT_CYCLES`-1, pulse `timeout_err`, discard the partial frame, return to IDLE and clear the prefix flags.
- Prefix decoding when `DECODE`=1:
  - Byte `F0` sets brk; byte `E0` sets ext. Neither byte is pushed.
  - Any other byte is pushed as {ext, brk, byte}, then both flags clear.
  - When `DECODE`=0, every good byte is pushed as {2'b0, byte}.
- FIFO:
  - A pop happens on `m_valid & m_ready`.
  - A push is accepted when the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - Otherwise the byte is dropped and `overflow` pulses.
  - A push and a pop in the same cycle leave `level` unchanged.
  - Pointers are $clog2(FIFO_DEPTH)+1 bits wide and wrap naturally. Full means the MSBs differ and the remaining bits are equal.
- Reset, asserted at any time (including mid-frame):
  - FSM returns to IDLE; all counters, pointers, flags and synchroniser flops clear.
  - Synchroniser flops reset to 1, the PS/2 idle level, so no spurious edge is detected after reset.
  - All outputs read 0: `m_valid`, `m_data`, `level`, and all four pulse outputs.

## Timing
- The stop-bit falling edge is seen at `clk` edge n, with the FSM entering CHECK at edge n. The FIFO write happens at edge n+1. `m_valid` and `level` update immediately after edge n+1.
- Pin-to-detection delay is `SYNC_STAGES`+1 cycles.
- Error and overflow pulses are registered, asserted for the cycle following edge n+1.
- `m_data` is show-ahead: it is valid whenever `m_valid`=1 and is stable until popped.
- At edge n+1, a pop and a push can occur together. This holds both when the FIFO holds one entry and when it is full.
- Throughput: one byte per PS/2 frame, about 11 PS/2 bit periods. The consumer can pop one entry per `clk` cycle.

## Structure
- Package `ps2_pkg` holds:
  - the `state_t` enum (IDLE, DATA, PARITY, STOP, CHECK);
  - constants `PS2_BREAK`=8'hF0 and `PS2_EXT`=8'hE0;
  - the packed struct `ps2_code_t` {ext, brk, code}.
- Sub-module `ps2_sync_fifo`: single-clock, show-ahead FIFO, parametrised in width and depth, with a `level` output. The receiver FSM, synchronisers, watchdog and decoder stay in the top module.

## Test plan
- Frame `1C` with correct parity and `m_ready`=1 → one entry `m_data`=10'h01C. `m_valid` pulses for one cycle, `level` returns to 0, no error pulses.
- With `DECODE`=1, send `E0`,`F0`,`75`, then `1C` → exactly two entries: 10'h375, then 10'h01C.
- Frame `1C` with a flipped parity bit → `parity_err` pulses once, nothing is pushed. Frame with stop bit 0 → `frame_err` pulses once.
- Stop `ps2_clk` after 4 data bits → `timeout_err` pulses at `TIMEOUT_CYCLES`-1. A following clean `29` frame is received as 10'h029.
- With `m_ready`=0, send 17 frames into a depth-16 FIFO → `level`=16 and one `overflow` pulse. Then send one frame with `m_ready`=1 held at that frame's CHECK+1 cycle → push accepted, `level` stays 16.
- Assert `rst` mid-frame after 5 bits → all outputs read 0 immediately. After release, a fresh frame `5A` is received as 10'h05A.
